// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcodes,
// branch condition codes, mux-select encodings and the controller state set.
// Used by the control unit, the datapath and the ALU decoder.
package riscv_ctrl_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [1:0] sel2_t;
  typedef logic [2:0] imm_sel_t;

  // Opcodes handled by the controller
  localparam opcode_t OP_LW     = 7'b0000011;
  localparam opcode_t OP_SW     = 7'b0100011;
  localparam opcode_t OP_R      = 7'b0110011;
  localparam opcode_t OP_IALU   = 7'b0010011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_JAL    = 7'b1101111;

  // Branch condition codes (funct3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU operand A select
  localparam sel2_t SRCA_PC    = 2'b00;
  localparam sel2_t SRCA_OLDPC = 2'b01;
  localparam sel2_t SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam sel2_t SRCB_RS2   = 2'b00;
  localparam sel2_t SRCB_IMM   = 2'b01;
  localparam sel2_t SRCB_FOUR  = 2'b10;

  // Result bus select
  localparam sel2_t RES_ALUOUT    = 2'b00;
  localparam sel2_t RES_DATA      = 2'b01;
  localparam sel2_t RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam imm_sel_t IMM_I = 3'b000;
  localparam imm_sel_t IMM_S = 3'b001;
  localparam imm_sel_t IMM_B = 3'b010;
  localparam imm_sel_t IMM_J = 3'b011;

  // ALU operation class handed to the ALU decoder
  localparam sel2_t ALUOP_ADD   = 2'b00;
  localparam sel2_t ALUOP_SUB   = 2'b01;
  localparam sel2_t ALUOP_FUNCT = 2'b10;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } ctrl_state_e;

  // True for the two opcodes that go through the address-generation state
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-path bundle between the multicycle controller and the datapath.
// The controller side (master) reads instruction fields, ALU flags and the
// memory ready strobe, and drives every enable and mux select.
interface multicycle_control_unit_if;
  import riscv_ctrl_pkg::*;

  // Instruction fields and status from the datapath
  opcode_t    Op;
  logic [2:0] funct3;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       mem_ready;

  // Enables and selects from the controller
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  sel2_t      ResultSrc;
  sel2_t      ALUSrcA;
  sel2_t      ALUSrcB;
  sel2_t      ALUOp;
  imm_sel_t   ImmSrc;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  Op, funct3, Zero, Lt, Ltu, mem_ready,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
           illegal_op, instr_done
  );

  modport slave (
    output Op, funct3, Zero, Lt, Ltu, mem_ready,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
           illegal_op, instr_done
  );

endinterface

// File: rtl/multicycle_control_unit_branch_unit.sv
// Branch condition evaluator: turns funct3 and the SrcA-SrcB subtraction
// flags into a taken decision, and flags condition codes this build rejects.
module branch_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit FULL_BRANCH = 1'b1
) (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       legal_o
);

  // Decode the condition; 010/011 are reserved, and a beq-only build rejects the rest
  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = !zero_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = !lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = !ltu_i;
      default: legal_o = 1'b0;
    endcase
    if (!FULL_BRANCH && (funct3_i != F3_BEQ)) begin
      taken_o = 1'b0;
      legal_o = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V main controller. A Moore machine walks each instruction
// through fetch, decode and 1-3 execute states over the shared memory and
// single ALU. Only PCWrite looks at the branch outcome, and only in BRANCH.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit FULL_BRANCH   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  ctrl_state_e state_q, state_d;

  logic     mem_done;
  logic     br_taken;
  logic     br_legal;

  logic     pc_update;
  logic     branch;
  logic     ir_write;
  logic     mem_write;
  logic     reg_write;
  logic     adr_src;
  logic     illegal;
  logic     done;
  sel2_t    result_src;
  sel2_t    alu_src_a;
  sel2_t    alu_src_b;
  sel2_t    alu_op;
  imm_sel_t imm_src;

  // Without the handshake every memory access is treated as single-cycle
  assign mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  branch_unit #(
    .FULL_BRANCH (FULL_BRANCH)
  ) u_branch (
    .funct3_i (bus.funct3),
    .zero_i   (bus.Zero),
    .lt_i     (bus.Lt),
    .ltu_i    (bus.Ltu),
    .taken_o  (br_taken),
    .legal_o  (br_legal)
  );

  // State register; reset drops straight back to FETCH and abandons any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state control decode, everything defaulted to idle first
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    done       = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_I;

    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        ir_write   = mem_done;
        pc_update  = mem_done;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        if (mem_done) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH: begin
            if (br_legal) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        imm_src   = (bus.Op == OP_SW) ? IMM_S : IMM_I;
        state_d   = (bus.Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_done) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        done       = mem_done;
        if (mem_done) state_d = S_FETCH;
      end

      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        imm_src   = IMM_I;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_J;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Write enables and pulses are held low for as long as reset is asserted
  assign bus.PCWrite    = rst_n & (pc_update | (branch & br_taken));
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.illegal_op = rst_n & illegal;
  assign bus.instr_done = rst_n & done;

  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.ImmSrc     = imm_src;

  // Unused-in-this-build guard: is_mem_op keeps decode intent visible to the datapath
  logic unused_mem_op;
  assign unused_mem_op = is_mem_op(bus.Op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for the multicycle controller: a table of per-cycle vectors for the
// directed cases, hand-driven reset and beq-only sequences, and a random
// instruction stream whose expected outputs come from an instruction-level model.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw, irw, mw, rw, adr, ill, done;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, lt, ltu, rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  vec_t q[$];

  outs_t P_F, P_FW, P_D, P_DI, P_MAL, P_MAS, P_MR, P_MWB, P_MW, P_MWW;
  outs_t P_EXR, P_EXI, P_AWB, P_JAL;

  multicycle_control_unit_if bus1 ();
  multicycle_control_unit_if bus2 ();

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .FULL_BRANCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .FULL_BRANCH(1'b0)) dut_min (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic pcw, irw, mw, rw, adr, ill, done,
                               input logic [1:0] rs, sa, sb, aop, input logic [2:0] imm);
    outs_t o;
    o = '{pcw, irw, mw, rw, adr, ill, done, rs, sa, sb, aop, imm};
    return o;
  endfunction

  function automatic outs_t brPhase(input logic taken);
    return mk(taken,0,0,0,0,0,1, 2'b00,2'b10,2'b00,2'b01,3'b000);
  endfunction

  function automatic outs_t grab(input bit onMin);
    outs_t o;
    if (onMin)
      o = '{bus2.PCWrite, bus2.IRWrite, bus2.MemWrite, bus2.RegWrite, bus2.AdrSrc,
            bus2.illegal_op, bus2.instr_done, bus2.ResultSrc, bus2.ALUSrcA,
            bus2.ALUSrcB, bus2.ALUOp, bus2.ImmSrc};
    else
      o = '{bus1.PCWrite, bus1.IRWrite, bus1.MemWrite, bus1.RegWrite, bus1.AdrSrc,
            bus1.illegal_op, bus1.instr_done, bus1.ResultSrc, bus1.ALUSrcA,
            bus1.ALUSrcB, bus1.ALUOp, bus1.ImmSrc};
    return o;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic z, lt, ltu, rdy,
                     input outs_t exp, input string name);
    vec_t v;
    v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.ltu = ltu; v.rdy = rdy;
    v.exp = exp; v.name = name;
    q.push_back(v);
  endtask

  task automatic checkOutput(input outs_t act, input outs_t exp, input string name);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge and check mid-low-phase
  task automatic applyStimulus(input vec_t v, input bit onMin);
    @(negedge clk);
    if (onMin) begin
      bus2.Op = v.op; bus2.funct3 = v.f3; bus2.Zero = v.z; bus2.Lt = v.lt;
      bus2.Ltu = v.ltu; bus2.mem_ready = v.rdy;
    end else begin
      bus1.Op = v.op; bus1.funct3 = v.f3; bus1.Zero = v.z; bus1.Lt = v.lt;
      bus1.Ltu = v.ltu; bus1.mem_ready = v.rdy;
    end
    #1;
    checkOutput(grab(onMin), v.exp, v.name);
  endtask

  task automatic runQueue(input bit onMin);
    foreach (q[i]) applyStimulus(q[i], onMin);
    q.delete();
  endtask

  // Instruction-level reference: expand one instruction into its expected cycles.
  // kind: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 branch, 5 jal, 6 unsupported opcode
  task automatic pushInstr(input int kind, input logic [2:0] f3, input logic [31:0] a, b,
                           input int fw, input int mw);
    logic [6:0] op;
    logic [6:0] bad [5];
    logic taken;
    bad = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b0001111, 7'b1110011};
    case (kind)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      default: op = bad[$urandom_range(0, 4)];
    endcase
    for (int i = 0; i < fw; i++) add(op, f3, rb(), rb(), rb(), 1'b0, P_FW, "rnd-fetch-wait");
    add(op, f3, rb(), rb(), rb(), 1'b1, P_F, "rnd-fetch");
    case (kind)
      0: begin
        add(op, f3, rb(), rb(), rb(), rb(), P_D, "rnd-lw-decode");
        add(op, f3, rb(), rb(), rb(), rb(), P_MAL, "rnd-lw-adr");
        for (int i = 0; i < mw; i++) add(op, f3, rb(), rb(), rb(), 1'b0, P_MR, "rnd-lw-wait");
        add(op, f3, rb(), rb(), rb(), 1'b1, P_MR, "rnd-lw-read");
        add(op, f3, rb(), rb(), rb(), rb(), P_MWB, "rnd-lw-wb");
      end
      1: begin
        add(op, f3, rb(), rb(), rb(), rb(), P_D, "rnd-sw-decode");
        add(op, f3, rb(), rb(), rb(), rb(), P_MAS, "rnd-sw-adr");
        for (int i = 0; i < mw; i++) add(op, f3, rb(), rb(), rb(), 1'b0, P_MWW, "rnd-sw-wait");
        add(op, f3, rb(), rb(), rb(), 1'b1, P_MW, "rnd-sw-write");
      end
      2, 3, 5: begin
        add(op, f3, rb(), rb(), rb(), rb(), P_D, "rnd-decode");
        add(op, f3, rb(), rb(), rb(), rb(),
            (kind == 2) ? P_EXR : (kind == 3) ? P_EXI : P_JAL, "rnd-exec");
        add(op, f3, rb(), rb(), rb(), rb(), P_AWB, "rnd-aluwb");
      end
      4: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          add(op, f3, rb(), rb(), rb(), rb(), P_DI, "rnd-br-illegal");
        end else begin
          case (f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) <  $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a <  b);
            default: taken = (a >= b);
          endcase
          add(op, f3, rb(), rb(), rb(), rb(), P_D, "rnd-br-decode");
          add(op, f3, (a == b), ($signed(a) < $signed(b)), (a < b), rb(),
              brPhase(taken), "rnd-br-resolve");
        end
      end
      default: add(op, f3, rb(), rb(), rb(), rb(), P_DI, "rnd-op-illegal");
    endcase
  endtask

  initial begin
    P_F   = mk(1,1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000);
    P_FW  = mk(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000);
    P_D   = mk(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b010);
    P_DI  = mk(0,0,0,0,0,1,0, 2'b00,2'b01,2'b01,2'b00,3'b010);
    P_MAL = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000);
    P_MAS = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b001);
    P_MR  = mk(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000);
    P_MWB = mk(0,0,0,1,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000);
    P_MW  = mk(0,0,1,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000);
    P_MWW = mk(0,0,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000);
    P_EXR = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b000);
    P_EXI = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,3'b000);
    P_AWB = mk(0,0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000);
    P_JAL = mk(1,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,3'b011);

    rst_n = 1'b0;
    bus1.Op = '0; bus1.funct3 = '0; bus1.Zero = 0; bus1.Lt = 0; bus1.Ltu = 0; bus1.mem_ready = 1;
    bus2.Op = '0; bus2.funct3 = '0; bus2.Zero = 0; bus2.Lt = 0; bus2.Ltu = 0; bus2.mem_ready = 1;
    #1;
    checkOutput(grab(1'b0), P_FW, "reset-outputs");
    checkOutput(grab(1'b1), P_FW, "reset-outputs-min");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed table: R with a fetch wait, lw with two read waits (7 cycles)
    add(7'b0110011, 3'b000, 0,0,0, 0, P_FW,  "fetch-wait");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_F,   "r-fetch");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_D,   "r-decode");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_EXR, "r-exec");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_AWB, "r-wb");
    add(7'b0000011, 3'b010, 0,0,0, 1, P_F,   "lw-fetch");
    add(7'b0000011, 3'b010, 0,0,0, 1, P_D,   "lw-decode");
    add(7'b0000011, 3'b010, 0,0,0, 1, P_MAL, "lw-adr");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MR,  "lw-wait1");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MR,  "lw-wait2");
    add(7'b0000011, 3'b010, 0,0,0, 1, P_MR,  "lw-read");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MWB, "lw-wb");
    // Branches: bne Zero=0 taken, bge Lt=1 not taken, bltu Ltu=1 taken
    add(7'b1100011, 3'b001, 0,0,0, 1, P_F,   "bne-fetch");
    add(7'b1100011, 3'b001, 0,0,0, 1, P_D,   "bne-decode");
    add(7'b1100011, 3'b001, 0,1,1, 1, brPhase(1'b1), "bne-taken");
    add(7'b1100011, 3'b101, 0,0,0, 1, P_F,   "bge-fetch");
    add(7'b1100011, 3'b101, 0,0,0, 1, P_D,   "bge-decode");
    add(7'b1100011, 3'b101, 0,1,0, 1, brPhase(1'b0), "bge-not-taken");
    add(7'b1100011, 3'b110, 0,0,0, 1, P_F,   "bltu-fetch");
    add(7'b1100011, 3'b110, 0,0,0, 1, P_D,   "bltu-decode");
    add(7'b1100011, 3'b110, 0,0,1, 1, brPhase(1'b1), "bltu-taken");
    // Mixed stream: I-ALU, sw with a write wait, jal
    add(7'b0010011, 3'b000, 0,0,0, 1, P_F,   "i-fetch");
    add(7'b0010011, 3'b000, 0,0,0, 1, P_D,   "i-decode");
    add(7'b0010011, 3'b000, 0,0,0, 1, P_EXI, "i-exec");
    add(7'b0010011, 3'b000, 0,0,0, 1, P_AWB, "i-wb");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_F,   "sw-fetch");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_D,   "sw-decode");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_MAS, "sw-adr");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_MWW, "sw-wait");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_MW,  "sw-write");
    add(7'b1101111, 3'b000, 0,0,0, 1, P_F,   "jal-fetch");
    add(7'b1101111, 3'b000, 0,0,0, 1, P_D,   "jal-decode");
    add(7'b1101111, 3'b000, 0,0,0, 1, P_JAL, "jal-exec");
    add(7'b1101111, 3'b000, 0,0,0, 1, P_AWB, "jal-wb");
    // Unknown opcode and reserved branch funct3 both end after DECODE
    add(7'b0110111, 3'b000, 0,0,0, 1, P_F,   "lui-fetch");
    add(7'b0110111, 3'b000, 0,0,0, 1, P_DI,  "lui-illegal");
    add(7'b1100011, 3'b010, 0,0,0, 1, P_F,   "br010-fetch");
    add(7'b1100011, 3'b010, 1,1,1, 1, P_DI,  "br010-illegal");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_F,   "after-illegal-fetch");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_D,   "after-illegal-decode");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_EXR, "after-illegal-exec");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_AWB, "after-illegal-wb");
    runQueue(1'b0);

    // Reset in the middle of a stalled MEMWRITE must drop MemWrite at once
    add(7'b0100011, 3'b010, 0,0,0, 1, P_F,   "rst-sw-fetch");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_D,   "rst-sw-decode");
    add(7'b0100011, 3'b010, 0,0,0, 1, P_MAS, "rst-sw-adr");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_MWW, "rst-sw-stall");
    runQueue(1'b0);
    #1 rst_n = 1'b0;
    #1 checkOutput(grab(1'b0), P_FW, "reset-mid-memwrite");
    @(posedge clk);
    #2 rst_n = 1'b1;
    add(7'b0110011, 3'b000, 0,0,0, 1, P_F,   "post-reset-fetch");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_D,   "post-reset-decode");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_EXR, "post-reset-exec");
    add(7'b0110011, 3'b000, 0,0,0, 1, P_AWB, "post-reset-wb");
    runQueue(1'b0);

    // Random instruction stream against the instruction-level model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pushInstr($urandom_range(0, 6), 3'($urandom_range(0, 7)), a, b,
                $urandom_range(0, 2), $urandom_range(0, 2));
      runQueue(1'b0);
    end

    // beq-only build without handshake: mem_ready held low and ignored
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    add(7'b1100011, 3'b001, 0,0,0, 0, P_F,   "min-bne-fetch");
    add(7'b1100011, 3'b001, 0,0,0, 0, P_DI,  "min-bne-illegal");
    add(7'b1100011, 3'b000, 0,0,0, 0, P_F,   "min-beq-fetch");
    add(7'b1100011, 3'b000, 0,0,0, 0, P_D,   "min-beq-decode");
    add(7'b1100011, 3'b000, 1,0,0, 0, brPhase(1'b1), "min-beq-taken");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_F,   "min-lw-fetch");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_D,   "min-lw-decode");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MAL, "min-lw-adr");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MR,  "min-lw-read");
    add(7'b0000011, 3'b010, 0,0,0, 0, P_MWB, "min-lw-wb");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_F,   "min-sw-fetch");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_D,   "min-sw-decode");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_MAS, "min-sw-adr");
    add(7'b0100011, 3'b010, 0,0,0, 0, P_MW,  "min-sw-write");
    add(7'b1100011, 3'b101, 0,1,0, 0, P_F,   "min-bge-fetch");
    add(7'b1100011, 3'b101, 0,1,0, 0, P_DI,  "min-bge-illegal");
    add(7'b1100011, 3'b000, 0,0,0, 0, P_F,   "min-beq2-fetch");
    add(7'b1100011, 3'b000, 0,0,0, 0, P_D,   "min-beq2-decode");
    add(7'b1100011, 3'b000, 0,1,1, 0, brPhase(1'b0), "min-beq-not-taken");
    runQueue(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
